// File: rtl/axi_lite_regfile_slave_if.sv
// rtl/axi_lite_regfile_slave_if.sv - AXI4-Lite channel bundle (AW/W/B/AR/R, 32-bit) with master/slave modports
interface axi_lite_regfile_slave_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_regfile_slave.sv
// rtl/axi_lite_regfile_slave.sv - AXI4-Lite register bank; AXIL_REGFILE_SLVERR_EN selects SLVERR on out-of-range access
module axi_lite_regfile_slave #(
    parameter int unsigned NUM_REGS  = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic                        aclk,
    input  logic                        areset,
    axi_lite_regfile_slave_if.slave     s_axi_lite,
    output logic [NUM_REGS*32-1:0]      reg_q,
    output logic                        wr_pulse,
    output logic [$clog2(NUM_REGS)-1:0] wr_idx
);
    localparam int unsigned IDX_W      = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT = 32'(NUM_REGS * 4);
`ifdef AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0]  OOB_RESP   = 2'b10;
`else
    localparam logic [1:0]  OOB_RESP   = 2'b00;
`endif

    logic [31:0]      regs [NUM_REGS];
    logic             aw_held;
    logic             w_held;
    logic [31:0]      aw_addr;
    logic [31:0]      w_data;
    logic [3:0]       w_strb;
    logic             bvalid;
    logic [1:0]       bresp;
    logic             rvalid;
    logic [1:0]       rresp;
    logic [31:0]      rdata;

    logic             aw_hs;
    logic             w_hs;
    logic             ar_hs;
    logic             commit;
    logic             w_in_range;
    logic             r_in_range;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] r_idx;

    assign s_axi_lite.awready = !areset && !aw_held;
    assign s_axi_lite.wready  = !areset && !w_held;
    assign s_axi_lite.arready = !areset && !rvalid;
    assign s_axi_lite.bvalid  = bvalid;
    assign s_axi_lite.bresp   = bresp;
    assign s_axi_lite.rvalid  = rvalid;
    assign s_axi_lite.rresp   = rresp;
    assign s_axi_lite.rdata   = rdata;

    assign aw_hs      = s_axi_lite.awvalid && s_axi_lite.awready;
    assign w_hs       = s_axi_lite.wvalid && s_axi_lite.wready;
    assign ar_hs      = s_axi_lite.arvalid && s_axi_lite.arready;
    // A held pair waits for the previous B to be accepted before committing.
    assign commit     = aw_held && w_held && !bvalid;
    assign w_in_range = aw_addr < ADDR_LIMIT;
    assign r_in_range = s_axi_lite.araddr < ADDR_LIMIT;
    assign w_idx      = aw_addr[2 +: IDX_W];
    assign r_idx      = s_axi_lite.araddr[2 +: IDX_W];

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_q[32*g +: 32] = regs[g];
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            aw_addr  <= '0;
            w_data   <= '0;
            w_strb   <= '0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            rvalid   <= 1'b0;
            rresp    <= 2'b00;
            rdata    <= '0;
            wr_pulse <= 1'b0;
            wr_idx   <= '0;
        end else begin
            wr_pulse <= 1'b0;

            if (aw_hs) begin
                aw_addr <= s_axi_lite.awaddr;
                aw_held <= 1'b1;
            end
            if (w_hs) begin
                w_data <= s_axi_lite.wdata;
                w_strb <= s_axi_lite.wstrb;
                w_held <= 1'b1;
            end

            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= w_in_range ? 2'b00 : OOB_RESP;
                if (w_in_range) begin
                    for (int k = 0; k < 4; k++)
                        if (w_strb[k]) regs[w_idx][8*k +: 8] <= w_data[8*k +: 8];
                    wr_pulse <= 1'b1;
                    wr_idx   <= w_idx;
                end
            end else if (s_axi_lite.bready) begin
                bvalid <= 1'b0;
            end

            // regs is read before any same-edge commit lands, so a collision returns the old value.
            if (ar_hs) begin
                rvalid <= 1'b1;
                rdata  <= r_in_range ? regs[r_idx] : 32'h0;
                rresp  <= r_in_range ? 2'b00 : OOB_RESP;
            end else if (s_axi_lite.rready) begin
                rvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// tb/tb_axi_lite_regfile_slave.sv - randomized self-checking bench for axi_lite_regfile_slave
module tb_axi_lite_regfile_slave;
    logic         aclk = 1'b0;
    logic         areset;
    logic [511:0] reg_q;
    logic         wr_pulse;
    logic [3:0]   wr_idx;
    int           n_checks = 0;
    int           n_fail = 0;
    logic [31:0]  model [16];

    axi_lite_regfile_slave_if axi ();

    axi_lite_regfile_slave #(.NUM_REGS(16), .RESET_VAL(32'h0)) dut (
        .aclk(aclk), .areset(areset), .s_axi_lite(axi),
        .reg_q(reg_q), .wr_pulse(wr_pulse), .wr_idx(wr_idx)
    );

    always #5 aclk = ~aclk;

    function automatic logic [511:0] model_flat();
        logic [511:0] f;
        for (int i = 0; i < 16; i++) f[32*i +: 32] = model[i];
        return f;
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
`ifdef AXIL_REGFILE_SLVERR_EN
        return (addr < 32'd64) ? 2'b00 : 2'b10;
`else
        return (addr < 32'd64) ? 2'b00 : 2'b00;
`endif
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        if (addr < 32'd64)
            for (int k = 0; k < 4; k++)
                if (strb[k]) model[addr / 4][8*k +: 8] = data[8*k +: 8];
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic pulse, output logic [3:0] idx, output int lat);
        int  n = 0;
        logic aw_done = 1'b0, w_done = 1'b0, aw_go, w_go;
        axi.awaddr = addr; axi.awvalid = 1'b1;
        axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1; axi.bready = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_go = axi.awvalid && axi.awready;
            w_go  = axi.wvalid && axi.wready;
            tick(); n++;
            if (aw_go) begin axi.awvalid = 1'b0; aw_done = 1'b1; end
            if (w_go)  begin axi.wvalid = 1'b0;  w_done = 1'b1;  end
        end
        lat = 0;
        while (!axi.bvalid && lat < 50) begin tick(); lat++; end
        n_checks++;
        if (!axi.bvalid) begin n_fail++; $display("FAIL write_timeout addr=%h bvalid=%b required 1", addr, axi.bvalid); end
        resp = axi.bresp; pulse = wr_pulse; idx = wr_idx;
        tick();
        axi.bready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp, output int lat);
        int n = 0;
        axi.araddr = addr; axi.arvalid = 1'b1; axi.rready = 1'b0;
        while (!axi.arready && n < 50) begin tick(); n++; end
        tick();
        axi.arvalid = 1'b0;
        lat = 0;
        while (!axi.rvalid && lat < 50) begin tick(); lat++; end
        n_checks++;
        if (!axi.rvalid) begin n_fail++; $display("FAIL read_timeout addr=%h rvalid=%b required 1", addr, axi.rvalid); end
        data = axi.rdata; resp = axi.rresp;
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        axi.awvalid = 0; axi.wvalid = 0; axi.arvalid = 0; axi.bready = 0; axi.rready = 0;
        axi.awaddr = 0; axi.wdata = 0; axi.wstrb = 0; axi.araddr = 0;
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        repeat (3) tick();
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready_low got=%b required 000", {axi.awready, axi.wready, axi.arready});
        end
        areset = 1'b0;
        tick();
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, wr_pulse} !== 6'b111000) begin
            n_fail++; $display("FAIL reset_flags got=%b required 111000",
                               {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid, wr_pulse});
        end
        n_checks++;
        if (reg_q !== model_flat() || axi.bresp !== 2'b00 || axi.rresp !== 2'b00 || axi.rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_values reg_q=%h rdata=%h required all zero", reg_q, axi.rdata);
        end
    endtask

    task automatic test_same_cycle_write();
        logic [1:0] resp; logic pulse; logic [3:0] idx; int lat; logic [31:0] data;
        do_write(32'h4, 32'hdeadbeef, 4'hF, resp, pulse, idx, lat);
        model_write(32'h4, 32'hdeadbeef, 4'hF);
        n_checks++;
        if (lat !== 1 || resp !== 2'b00 || pulse !== 1'b1 || idx !== 4'd1) begin
            n_fail++; $display("FAIL same_cycle_write lat=%0d resp=%b pulse=%b idx=%0d required 1/00/1/1", lat, resp, pulse, idx);
        end
        n_checks++;
        if (reg_q[63:32] !== 32'hdeadbeef) begin
            n_fail++; $display("FAIL same_cycle_reg1 got=%h required deadbeef", reg_q[63:32]);
        end
        n_checks++;
        if (wr_pulse !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_width got=%b required 0", wr_pulse); end
        do_read(32'h4, data, resp, lat);
        n_checks++;
        if (lat !== 0 || data !== 32'hdeadbeef || resp !== 2'b00) begin
            n_fail++; $display("FAIL read_back lat=%0d data=%h resp=%b required 0/deadbeef/00", lat, data, resp);
        end
    endtask

    task automatic test_w_before_aw();
        int bad = 0;
        axi.wdata = 32'h0000cafe; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.bready = 1'b1;
        tick();
        axi.wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (axi.wready !== 1'b0 || axi.bvalid !== 1'b0 || axi.awready !== 1'b1 || wr_pulse !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL w_held_no_commit bad_cycles=%0d required 0", bad); end
        axi.awaddr = 32'h14; axi.awvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0;
        n_checks++;
        if ({axi.awready, axi.wready, axi.bvalid} !== 3'b000) begin
            n_fail++; $display("FAIL both_held got=%b required 000", {axi.awready, axi.wready, axi.bvalid});
        end
        tick();
        model_write(32'h14, 32'h0000cafe, 4'hF);
        n_checks++;
        if (axi.bvalid !== 1'b1 || wr_pulse !== 1'b1 || wr_idx !== 4'd5 || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL w_first_commit bvalid=%b pulse=%b idx=%0d reg5=%h required 1/1/5/0000cafe",
                               axi.bvalid, wr_pulse, wr_idx, reg_q[191:160]);
        end
        tick();
        axi.bready = 1'b0;
    endtask

    task automatic test_strobe();
        logic [1:0] resp; logic pulse; logic [3:0] idx; int lat; logic [31:0] data;
        do_write(32'h8, 32'hdeadbeef, 4'hF, resp, pulse, idx, lat);
        do_write(32'h8, 32'h12345678, 4'b0011, resp, pulse, idx, lat);
        model_write(32'h8, 32'hdeadbeef, 4'hF);
        model_write(32'h8, 32'h12345678, 4'b0011);
        n_checks++;
        if (reg_q[95:64] !== 32'hdead5678) begin
            n_fail++; $display("FAIL strobe_reg2 got=%h required dead5678", reg_q[95:64]);
        end
        do_read(32'h8, data, resp, lat);
        n_checks++;
        if (data !== model[2]) begin n_fail++; $display("FAIL strobe_readback got=%h required %h", data, model[2]); end
    endtask

    task automatic test_backpressure();
        int bad = 0;
        axi.awaddr = 32'h18; axi.wdata = 32'ha5a5_0001; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        tick();
        model_write(32'h18, 32'ha5a5_0001, 4'hF);
        n_checks++;
        if (axi.bvalid !== 1'b1 || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL bp_first_commit bvalid=%b reg6=%h required 1/a5a50001", axi.bvalid, reg_q[223:192]);
        end
        axi.awaddr = 32'h1c; axi.wdata = 32'h5a5a_0002; axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (axi.bvalid !== 1'b1 || axi.bresp !== 2'b00 || axi.awready !== 1'b0 || axi.wready !== 1'b0 ||
                wr_pulse !== 1'b0 || reg_q !== model_flat()) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL bp_hold_stable bad_cycles=%0d required 0", bad); end
        axi.bready = 1'b1;
        tick();
        n_checks++;
        if (axi.bvalid !== 1'b0 || wr_pulse !== 1'b0) begin
            n_fail++; $display("FAIL bp_first_b_accept bvalid=%b pulse=%b required 0/0", axi.bvalid, wr_pulse);
        end
        tick();
        model_write(32'h1c, 32'h5a5a_0002, 4'hF);
        n_checks++;
        if (axi.bvalid !== 1'b1 || wr_pulse !== 1'b1 || wr_idx !== 4'd7 || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL bp_second_commit bvalid=%b pulse=%b idx=%0d reg7=%h required 1/1/7/5a5a0002",
                               axi.bvalid, wr_pulse, wr_idx, reg_q[255:224]);
        end
        tick();
        axi.bready = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [1:0] resp; logic pulse; logic [3:0] idx; int lat; logic [31:0] data;
        do_write(32'h40, 32'hffff_ffff, 4'hF, resp, pulse, idx, lat);
        n_checks++;
        if (resp !== exp_resp(32'h40) || pulse !== 1'b0 || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL oob_write resp=%b pulse=%b required %b/0 and no reg change", resp, pulse, exp_resp(32'h40));
        end
        do_read(32'h40, data, resp, lat);
        n_checks++;
        if (resp !== exp_resp(32'h40) || data !== 32'h0) begin
            n_fail++; $display("FAIL oob_read resp=%b data=%h required %b/00000000", resp, data, exp_resp(32'h40));
        end
    endtask

    task automatic test_collision();
        logic [1:0] resp; logic pulse; logic [3:0] idx; int lat;
        logic [31:0] old_v;
        do_write(32'h24, 32'h1111_2222, 4'hF, resp, pulse, idx, lat);
        model_write(32'h24, 32'h1111_2222, 4'hF);
        old_v = model[9];
        axi.awaddr = 32'h24; axi.wdata = 32'h3333_4444; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
        tick();
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        axi.araddr = 32'h24; axi.arvalid = 1'b1; axi.rready = 1'b0;
        tick();
        axi.arvalid = 1'b0;
        model_write(32'h24, 32'h3333_4444, 4'hF);
        n_checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== old_v || axi.bvalid !== 1'b1 || reg_q !== model_flat()) begin
            n_fail++; $display("FAIL collision rvalid=%b rdata=%h bvalid=%b reg9=%h required 1/%h/1/%h",
                               axi.rvalid, axi.rdata, axi.bvalid, reg_q[319:288], old_v, model[9]);
        end
        axi.rready = 1'b1;
        tick();
        axi.rready = 1'b0; axi.bready = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] resp; logic pulse; logic [3:0] idx; int lat;
        logic [31:0] addr, data, got;
        logic [3:0] strb;
        int bad_w = 0, bad_r = 0;
        for (int i = 0; i < 60; i++) begin
            addr = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) begin
                data = $urandom; strb = 4'($urandom_range(0, 15));
                do_write(addr, data, strb, resp, pulse, idx, lat);
                model_write(addr, data, strb);
                if (resp !== exp_resp(addr) || pulse !== (addr < 32'd64) || lat !== 1 ||
                    (addr < 32'd64 && idx !== 4'(addr / 4)) || reg_q !== model_flat()) begin
                    bad_w++;
                    $display("FAIL rand_write addr=%h resp=%b pulse=%b idx=%0d lat=%0d required resp=%b", addr, resp, pulse, idx, lat, exp_resp(addr));
                end
            end else begin
                do_read(addr, got, resp, lat);
                if (got !== ((addr < 32'd64) ? model[addr / 4] : 32'h0) || resp !== exp_resp(addr) || lat !== 0) begin
                    bad_r++;
                    $display("FAIL rand_read addr=%h data=%h resp=%b required data=%h resp=%b", addr, got, resp,
                             (addr < 32'd64) ? model[addr / 4] : 32'h0, exp_resp(addr));
                end
            end
        end
        n_checks++;
        if (bad_w != 0) n_fail++;
        n_checks++;
        if (bad_r != 0) n_fail++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] resp; logic pulse; logic [3:0] idx; int lat;
        do_write(32'hc, 32'h1, 4'hF, resp, pulse, idx, lat);
        axi.araddr = 32'hc; axi.arvalid = 1'b1; axi.rready = 1'b0;
        tick();
        axi.arvalid = 1'b0;
        axi.wdata = 32'hbad0_bad0; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
        tick();
        axi.wvalid = 1'b0;
        n_checks++;
        if (axi.rvalid !== 1'b1 || axi.rdata !== 32'h1) begin
            n_fail++; $display("FAIL pre_reset_read rvalid=%b rdata=%h required 1/00000001", axi.rvalid, axi.rdata);
        end
        areset = 1'b1;
        tick();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        n_checks++;
        if (axi.rvalid !== 1'b0 || reg_q !== model_flat() || {axi.awready, axi.wready, axi.arready} !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset rvalid=%b ready=%b reg_q_nonzero=%b required 0/000/0",
                               axi.rvalid, {axi.awready, axi.wready, axi.arready}, |reg_q);
        end
        tick();
        areset = 1'b0;
        tick();
        n_checks++;
        if ({axi.awready, axi.wready, axi.arready, axi.bvalid} !== 4'b1110) begin
            n_fail++; $display("FAIL post_reset ready_bvalid=%b required 1110", {axi.awready, axi.wready, axi.arready, axi.bvalid});
        end
    endtask

    initial begin
        test_reset();
        test_same_cycle_write();
        test_w_before_aw();
        test_strobe();
        test_backpressure();
        test_out_of_range();
        test_collision();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end
endmodule
